// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder and its storage array.
package mem_responder_pkg;

    localparam int DEFAULT_DEPTH = 64;
    localparam int DEFAULT_WAIT  = 2;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: synchronous write, asynchronous read, never reset.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Commit one word per cycle when enabled; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder: accepts one access, inserts WAIT_CYCLES wait
// states, then issues a one-cycle ready strobe with read data or an error.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               ready_q;
    logic               err_q;
    logic               busy_q;
    logic [31:0]        rdata_q;

    logic               acc_we;
    logic [31:0]        acc_addr;
    logic               acc_err;
    logic [31:0]        arr_rdata;
    logic [31:0]        resp_rdata;
    logic               arr_we;

    // Misaligned byte address or word index beyond the array.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    endfunction

    // The access being decoded: live inputs while accepting (zero-wait path),
    // the latched copy once the request has been taken.
    always_comb begin
        acc_we   = we_q;
        acc_addr = addr_q;
        if (state_q == ST_IDLE) begin
            acc_we   = we;
            acc_addr = addr;
        end
    end

    assign acc_err    = addr_bad(acc_addr);
    assign resp_rdata = (acc_we || acc_err) ? 32'h0 : arr_rdata;
    // err_q is already valid during RESP, so a faulting write never lands.
    assign arr_we     = (state_q == ST_RESP) && we_q && !err_q;

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (addr_q[IDX_W+1:2]),
        .wdata_i (wdata_q),
        .raddr_i (acc_addr[IDX_W+1:2]),
        .rdata_o (arr_rdata)
    );

    // Access FSM with registered response outputs and request latches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= ST_RESP;
                            ready_q <= 1'b1;
                            err_q   <= acc_err;
                            rdata_q <= resp_rdata;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_RESP;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        err_q   <= acc_err;
                        rdata_q <= resp_rdata;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    rdata_q <= 32'h0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    rdata_q <= 32'h0;
                end
            endcase
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule
